// File: rtl/net_seq_ctrl_if.sv
// Frame-in / result-out handshake bundle for net_seq_ctrl.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface net_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_out_0;
  logic [DATA_W-1:0] m_out_1;
  logic              m_timeout;
  logic              m_class;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_out_0, m_out_1, m_timeout, m_class
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_out_0, m_out_1, m_timeout, m_class
  );
endinterface

// File: rtl/net_seq_ctrl.sv
// Sequencer for the 7-in / 2-out MLP: loads a frame, runs the net under a watchdog, returns the result.
// Optional NET_ARGMAX_EN adds a registered signed argmax of the two outputs on m_class.
//
// state | meaning
// LOAD  | accepting frame words into net_data_*
// RUN   | net_in_rdy held, waiting for an armed net_rdy or the watchdog
// OUT   | result presented until m_valid & m_ready
module net_seq_ctrl #(
  parameter int DATA_W  = 32,
  parameter int N_IN    = 7,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  net_seq_ctrl_if.slave     bus,
  output logic [DATA_W-1:0] net_data_0,
  output logic [DATA_W-1:0] net_data_1,
  output logic [DATA_W-1:0] net_data_2,
  output logic [DATA_W-1:0] net_data_3,
  output logic [DATA_W-1:0] net_data_4,
  output logic [DATA_W-1:0] net_data_5,
  output logic [DATA_W-1:0] net_data_6,
  output logic              net_in_rdy,
  input  logic              net_rdy,
  input  logic [DATA_W-1:0] net_out_0,
  input  logic [DATA_W-1:0] net_out_1,
  output logic              busy,
  output logic [7:0]        err_cnt
);
  localparam int IDX_W = $clog2(N_IN);

  typedef enum logic [1:0] {LOAD, RUN, OUT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q [N_IN];
  logic [DATA_W-1:0] data_d [N_IN];
  logic [15:0]       wcnt_q, wcnt_d;
  logic              arm_q, arm_d;
  logic [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d;
  logic              to_q, to_d;
  logic [7:0]        err_q, err_d;
  logic              s_ready_q, s_ready_d;
  logic              in_rdy_q, in_rdy_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_q, busy_d;
`ifdef NET_ARGMAX_EN
  logic              class_q, class_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    arm_d   = arm_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    to_d    = to_q;
    err_d   = err_q;
`ifdef NET_ARGMAX_EN
    class_d = class_q;
`endif
    case (state_q)
      LOAD: begin
        // s_ready_q is only ever high in LOAD, so it doubles as the state qualifier
        if (bus.s_valid && s_ready_q) begin
          data_d[idx_q] = bus.s_data;
          if (idx_q == IDX_W'(N_IN - 1)) begin
            idx_d   = '0;
            wcnt_d  = '0;
            arm_d   = 1'b0;
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RUN: begin
        wcnt_d = wcnt_q + 16'd1;
        // a net_rdy still high from the previous frame must see a low first
        if (!net_rdy) arm_d = 1'b1;
        if (arm_q && net_rdy) begin
          out0_d  = net_out_0;
          out1_d  = net_out_1;
          to_d    = 1'b0;
`ifdef NET_ARGMAX_EN
          class_d = $signed(net_out_1) > $signed(net_out_0);
`endif
          state_d = OUT;
        end else if (wcnt_q == 16'(TIMEOUT - 1)) begin
          out0_d  = '0;
          out1_d  = '0;
          to_d    = 1'b1;
`ifdef NET_ARGMAX_EN
          class_d = 1'b0;
`endif
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_valid_q && bus.m_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = (state_d == LOAD);
    in_rdy_d  = (state_d == RUN);
    m_valid_d = (state_d == OUT);
    busy_d    = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      data_q    <= '{default: '0};
      wcnt_q    <= '0;
      arm_q     <= 1'b0;
      out0_q    <= '0;
      out1_q    <= '0;
      to_q      <= 1'b0;
      err_q     <= '0;
      s_ready_q <= 1'b0;
      in_rdy_q  <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef NET_ARGMAX_EN
      class_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wcnt_q    <= wcnt_d;
      arm_q     <= arm_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      to_q      <= to_d;
      err_q     <= err_d;
      s_ready_q <= s_ready_d;
      in_rdy_q  <= in_rdy_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
`ifdef NET_ARGMAX_EN
      class_q   <= class_d;
`endif
    end
  end

`ifdef NET_ARGMAX_EN
  assign bus.m_class = class_q;
`else
  assign bus.m_class = 1'b0;
`endif

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_out_0   = out0_q;
  assign bus.m_out_1   = out1_q;
  assign bus.m_timeout = to_q;
  assign net_in_rdy    = in_rdy_q;
  assign busy          = busy_q;
  assign err_cnt       = err_q;
  assign net_data_0    = data_q[0];
  assign net_data_1    = data_q[1];
  assign net_data_2    = data_q[2];
  assign net_data_3    = data_q[3];
  assign net_data_4    = data_q[4];
  assign net_data_5    = data_q[5];
  assign net_data_6    = data_q[6];
endmodule
